// File: rtl/div_seq_if.sv
// Request/response bundle for the sequential signed divider.
// The requester drives operands and start; the divider returns results and status.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             done;
  logic             div_zero;
  logic             busy;

  modport master (
    output start, dividend, divisor,
    input  lo, hi, done, div_zero, busy
  );

  modport slave (
    input  start, dividend, divisor,
    output lo, hi, done, div_zero, busy
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle signed divider: restoring shift-subtract on magnitudes, one quotient bit per clock.
// Quotient truncates toward zero (LO); remainder takes the dividend's sign (HI).
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  div_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    CALC,
    FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;

  // Two's-complement magnitudes; the most negative value maps onto itself as an unsigned magnitude.
  assign dividend_abs = dividend_q[WIDTH-1] ? (WIDTH'(0) - dividend_q) : dividend_q;
  assign divisor_abs  = divisor_q[WIDTH-1]  ? (WIDTH'(0) - divisor_q)  : divisor_q;

  // One extra bit keeps the trial difference's sign honest when the divisor magnitude is 2^(WIDTH-1).
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dmag_q};

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dmag_d     = dmag_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dividend_d = bus.dividend;
          divisor_d  = bus.divisor;
          state_d    = CHECK;
        end
      end

      CHECK: begin
        if (divisor_q == '0) begin
          done_d     = 1'b1;
          div_zero_d = 1'b1;
          state_d    = IDLE;
        end else begin
          quo_d     = dividend_abs;
          dmag_d    = divisor_abs;
          neg_quo_d = dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1];
          neg_rem_d = dividend_q[WIDTH-1];
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = CALC;
        end
      end

      CALC: begin
        // The dividend magnitude shifts out of quo's top while quotient bits shift in at the bottom.
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        lo_d    = neg_quo_q ? (WIDTH'(0) - quo_q) : quo_q;
        hi_d    = neg_rem_q ? (WIDTH'(0) - rem_q) : rem_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dmag_q     <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dmag_q     <= dmag_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      cnt_q      <= cnt_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.lo       = lo_q;
  assign bus.hi       = hi_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed operand pairs with hand-computed LO/HI,
// a negedge monitor that pops expectations whenever done pulses.
module tb_div_seq;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } expect_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  expect_t expect_q[$];

  div_seq_if #(.WIDTH(32)) bus ();

  div_seq #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Whenever the divider reports completion, compare against the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.done === 1'b1) begin
      if (expect_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done with lo=0x%08h hi=0x%08h, expected no done", bus.lo, bus.hi);
      end else begin
        expect_t e;
        e = expect_q.pop_front();
        check_output("lo", bus.lo, e.lo);
        check_output("hi", bus.hi, e.hi);
        check_output("div_zero", 32'(bus.div_zero), 32'(e.dz));
      end
    end
  end

  // Called at a negedge; returns 1ns after the start edge with start already dropped.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    check_output("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  // Counts edges after the start edge until done; an expired bound shows as a latency mismatch.
  task automatic wait_done(input string name, input int exp_cycles, input int elapsed);
    int  cycles;
    bit  seen;
    cycles = elapsed;
    seen   = 1'b0;
    while (!seen && cycles < 80) begin
      @(posedge clock);
      #1;
      cycles++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check_output({name, "_latency"}, 32'(cycles), 32'(exp_cycles));
    if (seen) begin
      check_output({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      @(posedge clock);
      #1;
      check_output({name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    end
    @(negedge clock);
  endtask

  task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lo, input logic [31:0] hi, input logic dz,
                        input int latency);
    expect_t e;
    e.lo = lo;
    e.hi = hi;
    e.dz = dz;
    expect_q.push_back(e);
    apply_stimulus(a, b);
    wait_done(name, latency, 0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    #1 reset = 1'b0;
    #1;
    check_output("reset_lo", bus.lo, 32'd0);
    check_output("reset_hi", bus.hi, 32'd0);
    check_output("reset_done", 32'(bus.done), 32'd0);
    check_output("reset_div_zero", 32'(bus.div_zero), 32'd0);
    check_output("reset_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    do_div("pos_pos",   32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34);
    do_div("div_zero",  32'd42,         32'd0,          32'd14,         32'd2,          1'b1, 1);
    do_div("neg_pos",   32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 34);
    do_div("pos_neg",   32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 34);
    do_div("min_by_m1", 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34);
    do_div("small",     32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 34);

    // A start pulse ten cycles into an operation must be dropped, not queued.
    begin
      expect_t e;
      e.lo = 32'd333;
      e.hi = 32'd1;
      e.dz = 1'b0;
      expect_q.push_back(e);
      apply_stimulus(32'd1000, 32'd3);
      repeat (9) @(posedge clock);
      @(negedge clock);
      bus.dividend = 32'd8;
      bus.divisor  = 32'd2;
      bus.start    = 1'b1;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      wait_done("ignored_start", 34, 10);
      repeat (40) @(negedge clock);
    end

    // start held through the done cycle launches exactly one more operation from IDLE.
    begin
      expect_t e;
      e.lo = 32'd3;
      e.hi = 32'd2;
      e.dz = 1'b0;
      expect_q.push_back(e);
      expect_q.push_back(e);
      bus.dividend = 32'd20;
      bus.divisor  = 32'd6;
      bus.start    = 1'b1;
      @(posedge clock);
      wait_done("held_first", 34, 0);
      bus.start = 1'b0;
      wait_done("held_second", 34, 0);
    end

    // Reset in the middle of CALC aborts with no completion pulse.
    apply_stimulus(32'd1000, 32'd3);
    repeat (13) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check_output("abort_lo", bus.lo, 32'd0);
    check_output("abort_hi", bus.hi, 32'd0);
    check_output("abort_done", 32'(bus.done), 32'd0);
    check_output("abort_div_zero", 32'(bus.div_zero), 32'd0);
    check_output("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    do_div("after_reset", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 34);

    repeat (40) @(negedge clock);
    check_output("scoreboard_empty", 32'(expect_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test by 200000, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; all values below assume 32.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a division request, sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, 32 bits: signed dividend (register A value).
REQ-006 The block SHALL have port divisor, input, 32 bits: signed divisor (register B value).
REQ-007 The block SHALL have port lo, output, 32 bits: signed quotient, written to LO.
REQ-008 The block SHALL have port hi, output, 32 bits: signed remainder, written to HI.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-010 The block SHALL have port div_zero, output, 1 bit: a one-cycle divide-by-zero pulse, coincident with done.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, CHECK, CALC and FINISH; IDLE is the reset state.
REQ-013 In IDLE, start=1 at edge E SHALL latch dividend and divisor into internal registers and move the FSM to CHECK.
REQ-014 After edge E, input changes SHALL NOT affect the operation in progress.
REQ-015 CHECK at edge E+1, divisor==0: the block SHALL pulse done=1 and div_zero=1 for one cycle, leave hi/lo unchanged, and return to IDLE.
REQ-016 CHECK at edge E+1, divisor!=0: the block SHALL latch |dividend|, |divisor| and the result signs, clear the partial remainder and the 6-bit counter, and enter CALC.
REQ-017 Absolute values SHALL be 32-bit two's-complement, so |0x80000000| is 0x80000000 treated as unsigned.
REQ-018 CALC SHALL perform one restoring shift-subtract step per edge, 32 edges (E+2..E+33); the counter SHALL increment each step, and the FSM SHALL leave CALC when the counter reaches 31.
REQ-019 Each step SHALL use a 33-bit trial subtraction so the unsigned 0x80000000 magnitudes do not overflow.
REQ-020 FINISH at edge E+34 SHALL register lo and hi and pulse done=1 (div_zero=0) for one cycle, then return to IDLE.
REQ-021 The quotient SHALL truncate toward zero and be negated when the operand signs differ.
REQ-022 The remainder SHALL take the sign of the dividend.
REQ-023 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 with no exception flag.
REQ-024 start asserted while busy=1 SHALL be ignored, not queued.
REQ-025 start held high in the cycle done=1 SHALL begin a new operation only from IDLE, on the following edge.
REQ-026 lo/hi SHALL hold their last completed results between operations and SHALL change only in FINISH.
REQ-027 busy SHALL be 1 from edge E through edge E+34 (normal case) or edge E+1 (divide-by-zero case).

Reset
REQ-028 reset=0 SHALL immediately, without a clock, force IDLE and lo=0, hi=0, done=0, div_zero=0, busy=0, and clear the counter and internal registers.
REQ-029 Reset mid-operation SHALL abort the operation with no done pulse; the next start after release SHALL run a full operation.

Verification
REQ-030 A bench SHALL cover: 100 / 7 -> lo=14, hi=2, done pulse 34 cycles after the start edge, div_zero=0.
REQ-031 A bench SHALL cover: 0xFFFFFF9C (-100) / 7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); also 100 / -7 -> lo=0xFFFFFFF2, hi=2.
REQ-032 A bench SHALL cover: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; and 5 / 9 -> lo=0, hi=5.
REQ-033 A bench SHALL cover: after 100/7, run 42 / 0 -> done=div_zero=1 one cycle after the start edge, lo=14 and hi=2 unchanged, busy low the next cycle.
REQ-034 A bench SHALL cover: start 1000/3 and pulse start with 8/2 ten cycles later -> only lo=333, hi=1 is produced, with exactly one done pulse.
REQ-035 A bench SHALL cover: reset=0 at cycle 12 of CALC -> all outputs 0 at once, no done; after release, 9/4 -> lo=2, hi=1.
